uart_tx_arbiter: RTL

Two-requester packet scheduler in front of `uart_tx`. It accepts fixed-length multi-byte packets from two game-side sources (e.g. player-0 and player-1 state reporters), grants the single UART transmitter round-robin, and serializes each packet byte-by-byte through the `tx_start`/`din`/`tx_done_tick` handshake. It sits between the game logic and `uart_tx`. `uart_tx` keeps its own baud tick and bit timing.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that feeds fixed-length packets from two requesters into one uart_tx.
// Define UART_ARB_HDR_EN to prefix every frame with header byte 8'hA0 | owner.
module uart_tx_arbiter #(
    parameter int PKT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [PKT_BYTES*8-1:0] data0,
    input  logic [PKT_BYTES*8-1:0] data1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   done0,
    output logic                   done1,
    output logic                   busy,
    output logic                   tx_start,
    output logic [7:0]             tx_din,
    input  logic                   tx_done_tick
);

`ifdef UART_ARB_HDR_EN
    localparam int FRAME_BYTES = PKT_BYTES + 1;
`else
    localparam int FRAME_BYTES = PKT_BYTES;
`endif
    localparam int         FW        = FRAME_BYTES * 8;
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t                 state, state_d;
    logic [FW-1:0]          frame, frame_d, frame_load;
    logic [3:0]             cnt, cnt_d;
    logic                   owner, owner_d;
    logic                   rr_last, rr_last_d;
    logic                   gnt0_d, gnt1_d, done0_d, done1_d, busy_d, tx_start_d;
    logic [7:0]             tx_din_d;
    logic                   pick0, pick1;
    logic [PKT_BYTES*8-1:0] payload;

    // On contention the requester that was not served last wins.
    assign pick0   = req0 && (!req1 || rr_last);
    assign pick1   = req1 && !pick0;
    assign payload = pick0 ? data0 : data1;

`ifdef UART_ARB_HDR_EN
    assign frame_load = {payload, 8'hA0 | {7'd0, pick1}};
`else
    assign frame_load = payload;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        frame_d    = frame;
        cnt_d      = cnt;
        owner_d    = owner;
        rr_last_d  = rr_last;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        busy_d     = busy;
        tx_start_d = 1'b0;
        tx_din_d   = tx_din;

        unique case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (pick0 || pick1) begin
                    frame_d   = frame_load;
                    owner_d   = pick1;
                    rr_last_d = pick1;
                    gnt0_d    = pick0;
                    gnt1_d    = pick1;
                    busy_d    = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tx_start_d = 1'b1;
                tx_din_d   = frame[7:0];
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    if (cnt == LAST_BYTE) begin
                        // busy stays up through the done cycle and drops in IDLE.
                        done0_d = !owner;
                        done1_d = owner;
                        state_d = S_IDLE;
                    end else begin
                        frame_d = frame >> 8;
                        cnt_d   = cnt + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            frame    <= '0;
            cnt      <= 4'd0;
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= 8'd0;
        end else begin
            state    <= state_d;
            frame    <= frame_d;
            cnt      <= cnt_d;
            owner    <= owner_d;
            rr_last  <= rr_last_d;
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            done0    <= done0_d;
            done1    <= done1_d;
            busy     <= busy_d;
            tx_start <= tx_start_d;
            tx_din   <= tx_din_d;
        end
    end

endmodule
